// File: rtl/msdap_pkg.sv
// Shared types for the MSDAP control block: fixed state encoding of the sequencing FSM.
package msdap_pkg;

  typedef enum logic [3:0] {
    INIT             = 4'd0,
    WAIT_FOR_RJ      = 4'd1,
    READING_RJ       = 4'd2,
    WAIT_FOR_COEFF   = 4'd3,
    READING_COEFF    = 4'd4,
    WAITING_FOR_DATA = 4'd5,
    WORKING          = 4'd6,
    CLEARING         = 4'd7,
    SLEEPING         = 4'd8
  } state_t;

endpackage

// File: rtl/msdap_control.sv
// Sequencing FSM for the MSDAP filter: load Rj, load coefficients, then process samples,
// with an async data-memory clear path and a sleep state for zero-input runs.
module msdap_control
  import msdap_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic frame,
  input  logic data_clear_complete,
  input  logic rj_count_done,
  input  logic coeff_count_done,
  input  logic s2p_done,
  input  logic conv_done,
  input  logic all_zeros,
  output logic mem_clear,
  output logic data_clear,
  output logic data_count_restart,
  output logic data_count_enable,
  output logic in_ready,
  output logic rj_wr_en,
  output logic coeff_wr_en,
  output logic data_wr_en,
  output logic rj_count_restart,
  output logic rj_count_enable,
  output logic coeff_count_restart,
  output logic coeff_count_enable,
  output logic s2p_clear,
  output logic alu_en,
  output logic alu_clear,
  output logic p2s_load,
  output logic p2s_clear
);

  state_t state, state_nxt;

  // Reset only clears data memory; Rj/coeff survive, so we resume at WAITING_FOR_DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEARING;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = INIT;
    else begin
      case (state)
        INIT:             state_nxt = WAIT_FOR_RJ;
        WAIT_FOR_RJ:      if (frame)            state_nxt = READING_RJ;
        READING_RJ:       if (rj_count_done)    state_nxt = WAIT_FOR_COEFF;
        WAIT_FOR_COEFF:   if (frame)            state_nxt = READING_COEFF;
        READING_COEFF:    if (coeff_count_done) state_nxt = WAITING_FOR_DATA;
        WAITING_FOR_DATA: if (frame)            state_nxt = WORKING;
        WORKING:          if (all_zeros)        state_nxt = SLEEPING;
        SLEEPING:         if (!all_zeros)       state_nxt = WORKING;
        CLEARING:         if (reset_n && data_clear_complete) state_nxt = WAITING_FOR_DATA;
        default:          state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    mem_clear           = 1'b0;
    data_clear          = 1'b0;
    data_count_restart  = 1'b0;
    data_count_enable   = 1'b0;
    in_ready            = 1'b0;
    rj_wr_en            = 1'b0;
    coeff_wr_en         = 1'b0;
    data_wr_en          = 1'b0;
    rj_count_restart    = 1'b0;
    rj_count_enable     = 1'b0;
    coeff_count_restart = 1'b0;
    coeff_count_enable  = 1'b0;
    s2p_clear           = 1'b0;
    alu_en              = 1'b0;
    alu_clear           = 1'b0;
    p2s_load            = 1'b0;
    p2s_clear           = 1'b0;
    case (state)
      INIT: begin
        mem_clear           = 1'b1;
        data_count_restart  = 1'b1;
        rj_count_restart    = 1'b1;
        coeff_count_restart = 1'b1;
        s2p_clear           = 1'b1;
        alu_clear           = 1'b1;
        p2s_clear           = 1'b1;
      end
      CLEARING: begin
        data_clear         = 1'b1;
        data_count_restart = 1'b1;
        s2p_clear          = 1'b1;
        alu_clear          = 1'b1;
        p2s_clear          = 1'b1;
      end
      WAIT_FOR_RJ, WAIT_FOR_COEFF, WAITING_FOR_DATA: in_ready = 1'b1;
      READING_RJ: begin
        in_ready        = 1'b1;
        rj_wr_en        = s2p_done;
        rj_count_enable = s2p_done;
      end
      READING_COEFF: begin
        in_ready           = 1'b1;
        coeff_wr_en        = s2p_done;
        coeff_count_enable = s2p_done;
      end
      WORKING: begin
        // A new sample restarts the convolution sweep over Rj/coeff and zeroes the sum.
        in_ready            = 1'b1;
        data_wr_en          = s2p_done;
        data_count_enable   = s2p_done;
        rj_count_restart    = s2p_done;
        coeff_count_restart = s2p_done;
        alu_clear           = s2p_done;
        alu_en              = ~conv_done & ~s2p_done;
        p2s_load            = conv_done;
      end
      SLEEPING: begin
        in_ready          = 1'b1;
        data_wr_en        = s2p_done;
        data_count_enable = s2p_done;
        p2s_clear         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msdap_control.sv
// Directed walk through the load/process/clear/sleep sequence, then random inputs,
// all checked against a rule-level model of the control FSM.
module tb_msdap_control;

  logic clk = 1'b0;
  logic reset_n, start, frame, data_clear_complete, rj_count_done, coeff_count_done;
  logic s2p_done, conv_done, all_zeros;
  logic mem_clear, data_clear, data_count_restart, data_count_enable, in_ready;
  logic rj_wr_en, coeff_wr_en, data_wr_en, rj_count_restart, rj_count_enable;
  logic coeff_count_restart, coeff_count_enable, s2p_clear, alu_en, alu_clear;
  logic p2s_load, p2s_clear;

  int passed = 0;
  int total  = 0;
  int m_state;  // model state, numbered as the documented encoding

  always #5 clk = ~clk;

  msdap_control dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame(frame),
    .data_clear_complete(data_clear_complete), .rj_count_done(rj_count_done),
    .coeff_count_done(coeff_count_done), .s2p_done(s2p_done), .conv_done(conv_done),
    .all_zeros(all_zeros), .mem_clear(mem_clear), .data_clear(data_clear),
    .data_count_restart(data_count_restart), .data_count_enable(data_count_enable),
    .in_ready(in_ready), .rj_wr_en(rj_wr_en), .coeff_wr_en(coeff_wr_en),
    .data_wr_en(data_wr_en), .rj_count_restart(rj_count_restart),
    .rj_count_enable(rj_count_enable), .coeff_count_restart(coeff_count_restart),
    .coeff_count_enable(coeff_count_enable), .s2p_clear(s2p_clear), .alu_en(alu_en),
    .alu_clear(alu_clear), .p2s_load(p2s_load), .p2s_clear(p2s_clear)
  );

  function automatic logic [16:0] obs();
    return {mem_clear, data_clear, data_count_restart, data_count_enable, in_ready,
            rj_wr_en, coeff_wr_en, data_wr_en, rj_count_restart, rj_count_enable,
            coeff_count_restart, coeff_count_enable, s2p_clear, alu_en, alu_clear,
            p2s_load, p2s_clear};
  endfunction

  // Expected outputs written as one rule per output signal.
  function automatic logic [16:0] model_out(int s);
    logic init, clr, work, sleep, mc, dc, dcr, dce, ir, rw, cw, dw, rr, re, cr, ce;
    logic sc, ae, ac, pl, pc;
    init  = (s == 0);
    clr   = (s == 7);
    work  = (s == 6);
    sleep = (s == 8);
    mc  = init;
    dc  = clr;
    dcr = init | clr;
    ir  = !(init | clr);
    rw  = (s == 2) & s2p_done;
    re  = rw;
    cw  = (s == 4) & s2p_done;
    ce  = cw;
    dw  = (work | sleep) & s2p_done;
    dce = dw;
    rr  = init | (work & s2p_done);
    cr  = rr;
    sc  = init | clr;
    ac  = init | clr | (work & s2p_done);
    ae  = work & !conv_done & !s2p_done;
    pl  = work & conv_done;
    pc  = init | clr | sleep;
    return {mc, dc, dcr, dce, ir, rw, cw, dw, rr, re, cr, ce, sc, ae, ac, pl, pc};
  endfunction

  function automatic int model_next(int s);
    if (start) return 0;
    case (s)
      0: return 1;
      1: return frame ? 2 : 1;
      2: return rj_count_done ? 3 : 2;
      3: return frame ? 4 : 3;
      4: return coeff_count_done ? 5 : 4;
      5: return frame ? 6 : 5;
      6: return all_zeros ? 8 : 6;
      8: return all_zeros ? 8 : 6;
      7: return data_clear_complete ? 5 : 7;
      default: return 0;
    endcase
  endfunction

  // Drive inputs shortly after a rising edge, check at the falling edge, advance model.
  task automatic step(input logic st, rn, fr, dcc, rjd, cd, s2p, cv, az, input string tag);
    logic [16:0] exp_o, got_o;
    logic [3:0]  got_s;
    start = st; reset_n = rn; frame = fr; data_clear_complete = dcc;
    rj_count_done = rjd; coeff_count_done = cd; s2p_done = s2p; conv_done = cv;
    all_zeros = az;
    if (!rn) m_state = 7;
    @(negedge clk);
    exp_o = model_out(m_state);
    got_o = obs();
    got_s = dut.state;
    total++;
    assert (got_o === exp_o) passed++;
    else $error("FAIL %s outputs: got %b expected %b (model state %0d)", tag, got_o, exp_o, m_state);
    total++;
    assert (got_s === 4'(m_state)) passed++;
    else $error("FAIL %s state: got %0d expected %0d", tag, got_s, m_state);
    @(posedge clk);
    m_state = reset_n ? model_next(m_state) : 7;
    #1;
  endtask

  initial begin
    m_state = 7;
    // power-up in reset, then start pulse
    step(0,0,0,0,0,0,0,0,0, "reset");
    step(1,1,0,0,0,0,0,0,0, "start_from_clear");
    step(0,1,0,0,0,0,0,0,0, "init");
    step(0,1,0,0,0,0,0,0,0, "wait_rj");
    step(0,1,1,0,0,0,0,0,0, "wait_rj_frame");
    step(0,1,0,0,0,0,1,0,0, "rj_write");
    step(0,1,0,0,1,0,1,0,0, "rj_done_with_write");
    step(0,1,1,0,0,0,0,0,0, "wait_coeff_frame");
    step(0,1,0,0,0,0,1,0,0, "coeff_write");
    step(0,1,0,0,0,1,0,0,0, "coeff_done");
    step(0,1,1,0,0,0,0,0,0, "wait_data_frame");
    step(0,1,0,0,0,0,0,0,0, "working_alu");
    step(0,1,0,0,0,0,1,0,0, "working_sample");
    step(0,1,0,0,0,0,0,1,0, "working_conv_done");
    step(0,1,0,0,0,0,1,1,0, "working_both");
    // async reset while working
    step(0,0,0,0,0,0,0,0,0, "reset_mid_work");
    step(0,1,0,0,0,0,0,0,0, "clearing_hold");
    step(0,1,0,1,0,0,0,0,0, "clear_complete");
    step(0,1,1,0,0,0,0,0,0, "data_frame_again");
    step(0,1,0,0,0,0,0,0,1, "to_sleep");
    step(0,1,0,0,0,0,1,0,1, "sleep_write");
    step(0,1,0,0,0,0,0,0,0, "wake");
    step(0,1,0,0,0,0,0,0,1, "sleep_again");
    step(1,1,0,0,0,0,0,0,1, "start_from_sleep");
    step(0,1,0,0,0,0,0,0,0, "init2");
    step(0,1,1,0,0,0,0,0,0, "rj_frame2");
    step(0,0,0,0,0,0,0,0,0, "reset_in_rj_load");
    step(1,1,0,0,0,0,0,0,0, "start_from_clearing");
    step(0,1,0,0,0,0,0,0,0, "init3");
    // random phase
    for (int i = 0; i < 600; i++) begin
      logic rn, st;
      rn = ($urandom_range(0, 39) != 0);
      st = rn && ($urandom_range(0, 29) == 0);
      step(st, rn, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, "random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
